cache_sram_1rw1r: RTL and testbench
===================================

CACHE_SRAM_1RW1R -- requirements
Module: cache_sram_1rw1r

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, address width; DEPTH = 2**ADDR_WIDTH words.
REQ-003 SHALL have parameter LANE_WIDTH, default 8, bits per write-mask lane; NUM_WMASKS = DATA_WIDTH/LANE_WIDTH.
REQ-004 SHALL have parameter OUT_REG, default 0, read latency select: 0 -> 1 cycle, 1 -> 2 cycles.
REQ-005 SHALL have parameter CLEAR_ON_RESET, default 1, zero-fill the array after reset when 1.
REQ-006 SHALL have port clk, input, 1, sole clock; all logic on posedge.
REQ-007 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port init_busy, output, 1, high while the clear sequence runs.
REQ-009 SHALL have port csb0, input, 1, port 0 active-low select.
REQ-010 SHALL have port web0, input, 1, port 0 active-low write enable.
REQ-011 SHALL have port wmask0, input, NUM_WMASKS, per-lane write enable.
REQ-012 SHALL have port addr0, input, ADDR_WIDTH, port 0 address.
REQ-013 SHALL have port din0, input, DATA_WIDTH, port 0 write data.
REQ-014 SHALL have port dout0, output, DATA_WIDTH, port 0 read data.
REQ-015 SHALL have port dout0_valid, output, 1, dout0 carries a fresh read.
REQ-016 SHALL have port csb1, input, 1, port 1 (read-only) active-low select.
REQ-017 SHALL have port addr1, input, ADDR_WIDTH, port 1 address.
REQ-018 SHALL have port dout1, output, DATA_WIDTH, port 1 read data.
REQ-019 SHALL have port dout1_valid, output, 1, dout1 carries a fresh read.

Function
REQ-020 Write SHALL occur at the posedge where csb0=0, web0=0, init_busy=0, updating only lanes whose wmask0 bit is 1.
REQ-021 Read SHALL be accepted at the posedge where csbN=0 (and web0=1 for port 0) and init_busy=0; data and doutN_valid=1 appear 1+OUT_REG cycles later.
REQ-022 doutN_valid SHALL be a single-cycle pulse per accepted read; doutN SHALL hold its last value otherwise (never X).
REQ-023 Port 1 reading the address port 0 writes in the same cycle SHALL return write-first data: masked lanes from din0, other lanes from the array.
REQ-024 Clear FSM SHALL have states CLEAR and READY; reset enters CLEAR if CLEAR_ON_RESET=1, else READY.
REQ-025 In CLEAR, an ADDR_WIDTH counter SHALL write zero to one address per cycle from 0 to DEPTH-1, then go to READY; the clear takes exactly DEPTH cycles.
REQ-026 init_busy SHALL be 1 exactly while in CLEAR; requests presented during CLEAR SHALL be dropped with no write and no valid pulse.
REQ-027 Reads in flight in the OUT_REG pipeline SHALL complete normally; the pipeline SHALL NOT stall.

Reset
REQ-028 Asserting rst_n=0 at any time, including mid-clear, SHALL immediately set dout0=dout1=0, valids=0, counter=0, init_busy=CLEAR_ON_RESET.
REQ-029 The memory array SHALL NOT be reset; with CLEAR_ON_RESET=0 its contents are undefined until written.

Structure
REQ-030 Package cache_sram_pkg SHALL hold default parameter constants and the clear-FSM state enum.
REQ-031 Sub-module cache_sram_rdport (latency/valid/hold pipeline) SHALL be instantiated once per read port.

Verification
REQ-032 Reset release, CLEAR_ON_RESET=1, ADDR_WIDTH=8 -> init_busy high 256 cycles; then read addr 0xFF -> 0x00000000, valid after 1 cycle.
REQ-033 Write 0xDEADBEEF @0x10 mask 4'b1111, then write 0x11223344 mask 4'b0101 -> read @0x10 returns 0xDE22BE44.
REQ-034 Same cycle: port0 write 0xCAFEF00D mask 4'b1100 @0x20 (old 0x12345678), port1 read @0x20 -> dout1=0xCAFE5678.
REQ-035 OUT_REG=1: back-to-back port0 reads @1,@2 (0xA,0xB) -> dout0 0xA then 0xB, 2 cycles after each request, valid pulsed each cycle.
REQ-036 rst_n pulsed low at clear count 100 -> outputs 0 immediately; clear restarts from 0 and takes full 256 cycles.
REQ-037 Port1 read during init_busy=1 -> no dout1_valid pulse, dout1 stays 0.

Source files
------------

// File: rtl/cache_sram_pkg.sv
// rtl/cache_sram_pkg.sv - shared constants and clear-FSM state type for the cache SRAM
//
// Purpose : default parameter values and the clear sequencer state enum,
//           imported by cache_sram_1rw1r and cache_sram_rdport.
// Ports   : none (package).

package cache_sram_pkg;

  localparam int DEFAULT_DATA_WIDTH     = 32;
  localparam int DEFAULT_ADDR_WIDTH     = 8;
  localparam int DEFAULT_LANE_WIDTH     = 8;
  localparam int DEFAULT_OUT_REG        = 0;
  localparam int DEFAULT_CLEAR_ON_RESET = 1;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } clr_state_e;

endpackage

// File: rtl/cache_sram_rdport.sv
// rtl/cache_sram_rdport.sv - read latency / valid / hold pipeline for one SRAM read port
//
// Purpose : captures read data on an accepted read and presents it after
//           1 (OUT_REG=0) or 2 (OUT_REG=1) cycles with a one-cycle valid pulse.
//           The output holds its last value between reads.
// Ports   : clk, rst_n     - clock, asynchronous active-low reset
//           rd_en_i        - read accepted at this edge
//           rd_data_i      - array data for the accepted address (combinational)
//           dout_o         - read data, zero after reset, held between reads
//           valid_o        - single-cycle pulse marking fresh dout_o

module cache_sram_rdport
  import cache_sram_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int OUT_REG    = DEFAULT_OUT_REG
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_en_i,
  input  logic [DATA_WIDTH-1:0] rd_data_i,
  output logic [DATA_WIDTH-1:0] dout_o,
  output logic                  valid_o
);

  logic [DATA_WIDTH-1:0] s1_data_q, s1_data_d;
  logic                  s1_valid_q;

  // Stage 1 only loads on an accepted read so the value is held otherwise.
  always_comb begin
    s1_data_d = s1_data_q;
    if (rd_en_i) begin
      s1_data_d = rd_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_data_q  <= '0;
      s1_valid_q <= 1'b0;
    end else begin
      s1_data_q  <= s1_data_d;
      s1_valid_q <= rd_en_i;
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic [DATA_WIDTH-1:0] s2_data_q, s2_data_d;
    logic                  s2_valid_q;

    // Second stage advances only behind a valid first stage; it never stalls.
    always_comb begin
      s2_data_d = s2_data_q;
      if (s1_valid_q) begin
        s2_data_d = s1_data_q;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s2_data_q  <= '0;
        s2_valid_q <= 1'b0;
      end else begin
        s2_data_q  <= s2_data_d;
        s2_valid_q <= s1_valid_q;
      end
    end

    assign dout_o  = s2_data_q;
    assign valid_o = s2_valid_q;
  end else begin : g_no_out_reg
    assign dout_o  = s1_data_q;
    assign valid_o = s1_valid_q;
  end

endmodule

// File: rtl/cache_sram_1rw1r.sv
// rtl/cache_sram_1rw1r.sv - 1RW + 1R cache SRAM with lane write masks and clear-on-reset
//
// Purpose : DEPTH x DATA_WIDTH array. Port 0 reads or writes (lane-masked),
//           port 1 reads only with write-first forwarding from port 0. After
//           reset an optional sequencer zero-fills the array one word per cycle.
// Ports   : clk, rst_n                    - clock, asynchronous active-low reset
//           init_busy                     - high while the clear sequence runs
//           csb0, web0, wmask0, addr0, din0 - port 0 request (active-low select/write)
//           dout0, dout0_valid            - port 0 read data and fresh-data pulse
//           csb1, addr1                   - port 1 request (active-low select)
//           dout1, dout1_valid            - port 1 read data and fresh-data pulse

module cache_sram_1rw1r
  import cache_sram_pkg::*;
#(
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
  parameter int LANE_WIDTH     = DEFAULT_LANE_WIDTH,
  parameter int OUT_REG        = DEFAULT_OUT_REG,
  parameter int CLEAR_ON_RESET = DEFAULT_CLEAR_ON_RESET,
  localparam int NUM_WMASKS    = DATA_WIDTH / LANE_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  init_busy,
  input  logic                  csb0,
  input  logic                  web0,
  input  logic [NUM_WMASKS-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] din0,
  output logic [DATA_WIDTH-1:0] dout0,
  output logic                  dout0_valid,
  input  logic                  csb1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic [DATA_WIDTH-1:0] dout1,
  output logic                  dout1_valid
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  clr_state_e            state_q;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic                  init_busy_q;

  logic                  wr_en;
  logic                  rd0_en;
  logic                  rd1_en;
  logic [DATA_WIDTH-1:0] rd0_data;
  logic [DATA_WIDTH-1:0] rd1_data;

  // Clear sequencer: walks cnt_q over every address once, then parks in READY.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      cnt_q       <= '0;
      init_busy_q <= (CLEAR_ON_RESET != 0);
    end else begin
      case (state_q)
        ST_CLEAR: begin
          cnt_q <= cnt_q + ADDR_WIDTH'(1);
          if (cnt_q == {ADDR_WIDTH{1'b1}}) begin
            state_q     <= ST_READY;
            init_busy_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= ST_READY;
          init_busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign init_busy = init_busy_q;

  // rst_n gating keeps a port-0 write from landing while reset is held
  // in the no-clear configuration, where init_busy is already low.
  assign wr_en  = !csb0 && !web0 && !init_busy_q && rst_n;
  assign rd0_en = !csb0 &&  web0 && !init_busy_q;
  assign rd1_en = !csb1 && !init_busy_q;

  // The array itself has no reset; only the clear sequencer zeroes it.
  always_ff @(posedge clk) begin
    if (state_q == ST_CLEAR) begin
      mem_q[cnt_q] <= '0;
    end else if (wr_en) begin
      for (int l = 0; l < NUM_WMASKS; l++) begin
        if (wmask0[l]) begin
          mem_q[addr0][l*LANE_WIDTH +: LANE_WIDTH] <= din0[l*LANE_WIDTH +: LANE_WIDTH];
        end
      end
    end
  end

  // Port 0 cannot read and write at once, so it never needs forwarding.
  assign rd0_data = mem_q[addr0];

  // Port 1 sees the word as it will be after this edge's port-0 write.
  always_comb begin
    rd1_data = mem_q[addr1];
    if (wr_en && (addr0 == addr1)) begin
      for (int l = 0; l < NUM_WMASKS; l++) begin
        if (wmask0[l]) begin
          rd1_data[l*LANE_WIDTH +: LANE_WIDTH] = din0[l*LANE_WIDTH +: LANE_WIDTH];
        end
      end
    end
  end

  cache_sram_rdport #(
    .DATA_WIDTH (DATA_WIDTH),
    .OUT_REG    (OUT_REG)
  ) u_rdport0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_en_i   (rd0_en),
    .rd_data_i (rd0_data),
    .dout_o    (dout0),
    .valid_o   (dout0_valid)
  );

  cache_sram_rdport #(
    .DATA_WIDTH (DATA_WIDTH),
    .OUT_REG    (OUT_REG)
  ) u_rdport1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_en_i   (rd1_en),
    .rd_data_i (rd1_data),
    .dout_o    (dout1),
    .valid_o   (dout1_valid)
  );

endmodule

// File: tb/tb_cache_sram_1rw1r.sv
// tb/tb_cache_sram_1rw1r.sv - directed self-checking bench for cache_sram_1rw1r

module tb_cache_sram_1rw1r;

  logic        clk = 1'b0;
  logic        rst_n;
  int          checks = 0;
  int          errors = 0;

  // u0: OUT_REG=0 instance
  logic        init_busy;
  logic        csb0, web0, csb1;
  logic [3:0]  wmask0;
  logic [7:0]  addr0, addr1;
  logic [31:0] din0, dout0, dout1;
  logic        dout0_valid, dout1_valid;

  // u1: OUT_REG=1 instance
  logic        init_busy_r;
  logic        csb0_r, web0_r, csb1_r;
  logic [3:0]  wmask0_r;
  logic [7:0]  addr0_r, addr1_r;
  logic [31:0] din0_r, dout0_r, dout1_r;
  logic        dout0_valid_r, dout1_valid_r;

  always #5 clk = ~clk;

  cache_sram_1rw1r #(.OUT_REG(0)) u0 (
    .clk(clk), .rst_n(rst_n), .init_busy(init_busy),
    .csb0(csb0), .web0(web0), .wmask0(wmask0), .addr0(addr0), .din0(din0),
    .dout0(dout0), .dout0_valid(dout0_valid),
    .csb1(csb1), .addr1(addr1), .dout1(dout1), .dout1_valid(dout1_valid)
  );

  cache_sram_1rw1r #(.OUT_REG(1)) u1 (
    .clk(clk), .rst_n(rst_n), .init_busy(init_busy_r),
    .csb0(csb0_r), .web0(web0_r), .wmask0(wmask0_r), .addr0(addr0_r), .din0(din0_r),
    .dout0(dout0_r), .dout0_valid(dout0_valid_r),
    .csb1(csb1_r), .addr1(addr1_r), .dout1(dout1_r), .dout1_valid(dout1_valid_r)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    csb0 = 1'b1; web0 = 1'b1; wmask0 = 4'h0; addr0 = 8'h00; din0 = 32'h0;
    csb1 = 1'b1; addr1 = 8'h00;
    csb0_r = 1'b1; web0_r = 1'b1; wmask0_r = 4'h0; addr0_r = 8'h00; din0_r = 32'h0;
    csb1_r = 1'b1; addr1_r = 8'h00;
  endtask

  task automatic wr0(input logic [7:0] a, input logic [31:0] d, input logic [3:0] m);
    csb0 = 1'b0; web0 = 1'b0; addr0 = a; din0 = d; wmask0 = m;
    step();
    csb0 = 1'b1; web0 = 1'b1; wmask0 = 4'h0;
  endtask

  task automatic test_reset();
    int n;
    idle();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (dout0 !== 32'h0 || dout1 !== 32'h0 || dout0_valid !== 1'b0 || dout1_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: dout0=%h dout1=%h v0=%b v1=%b, want 0/0/0/0",
               dout0, dout1, dout0_valid, dout1_valid);
    end
    checks++;
    if (init_busy !== 1'b1 || init_busy_r !== 1'b1) begin
      errors++;
      $display("FAIL reset_init_busy: got %b/%b, want 1/1", init_busy, init_busy_r);
    end
    step();
    step();
    rst_n = 1'b1;
    n = 0;
    while (init_busy === 1'b1 && n < 400) begin
      step();
      n++;
    end
    checks++;
    if (n != 256) begin
      errors++;
      $display("FAIL clear_length: got %0d cycles, want 256", n);
    end
    checks++;
    if (init_busy_r !== 1'b0) begin
      errors++;
      $display("FAIL clear_done_u1: init_busy=%b, want 0", init_busy_r);
    end
    csb0 = 1'b0; web0 = 1'b1; addr0 = 8'hFF;
    csb1 = 1'b0; addr1 = 8'hFF;
    step();
    idle();
    checks++;
    if (dout0 !== 32'h0 || dout0_valid !== 1'b1 || dout1 !== 32'h0 || dout1_valid !== 1'b1) begin
      errors++;
      $display("FAIL read_ff_after_clear: d0=%h v0=%b d1=%h v1=%b, want 0/1/0/1",
               dout0, dout0_valid, dout1, dout1_valid);
    end
    step();
    checks++;
    if (dout0_valid !== 1'b0 || dout1_valid !== 1'b0) begin
      errors++;
      $display("FAIL valid_pulse: v0=%b v1=%b, want 0/0", dout0_valid, dout1_valid);
    end
  endtask

  task automatic test_mask();
    wr0(8'h10, 32'hDEADBEEF, 4'b1111);
    checks++;
    if (dout0_valid !== 1'b0) begin
      errors++;
      $display("FAIL write_no_valid: v0=%b, want 0", dout0_valid);
    end
    wr0(8'h10, 32'h11223344, 4'b0101);
    csb0 = 1'b0; web0 = 1'b1; addr0 = 8'h10;
    step();
    idle();
    checks++;
    if (dout0 !== 32'hDE22BE44 || dout0_valid !== 1'b1) begin
      errors++;
      $display("FAIL mask_merge: dout0=%h v=%b, want DE22BE44/1", dout0, dout0_valid);
    end
    step();
    checks++;
    if (dout0 !== 32'hDE22BE44 || dout0_valid !== 1'b0) begin
      errors++;
      $display("FAIL dout0_hold: dout0=%h v=%b, want DE22BE44/0", dout0, dout0_valid);
    end
  endtask

  task automatic test_write_first();
    wr0(8'h20, 32'h12345678, 4'b1111);
    csb0 = 1'b0; web0 = 1'b0; addr0 = 8'h20; din0 = 32'hCAFEF00D; wmask0 = 4'b1100;
    csb1 = 1'b0; addr1 = 8'h20;
    step();
    idle();
    checks++;
    if (dout1 !== 32'hCAFE5678 || dout1_valid !== 1'b1) begin
      errors++;
      $display("FAIL write_first: dout1=%h v=%b, want CAFE5678/1", dout1, dout1_valid);
    end
    csb0 = 1'b0; web0 = 1'b1; addr0 = 8'h20;
    step();
    idle();
    checks++;
    if (dout0 !== 32'hCAFE5678) begin
      errors++;
      $display("FAIL write_first_array: dout0=%h, want CAFE5678", dout0);
    end
    step();
    checks++;
    if (dout1 !== 32'hCAFE5678 || dout1_valid !== 1'b0) begin
      errors++;
      $display("FAIL dout1_hold: dout1=%h v=%b, want CAFE5678/0", dout1, dout1_valid);
    end
  endtask

  task automatic test_back_to_back();
    csb0_r = 1'b0; web0_r = 1'b0; wmask0_r = 4'hF; addr0_r = 8'h01; din0_r = 32'hA;
    step();
    addr0_r = 8'h02; din0_r = 32'hB;
    step();
    web0_r = 1'b1; wmask0_r = 4'h0; addr0_r = 8'h01;
    step();
    checks++;
    if (dout0_valid_r !== 1'b0) begin
      errors++;
      $display("FAIL outreg_latency: valid after 1 cycle=%b, want 0", dout0_valid_r);
    end
    addr0_r = 8'h02;
    step();
    csb0_r = 1'b1;
    checks++;
    if (dout0_r !== 32'hA || dout0_valid_r !== 1'b1) begin
      errors++;
      $display("FAIL outreg_first: dout0=%h v=%b, want 0000000a/1", dout0_r, dout0_valid_r);
    end
    step();
    checks++;
    if (dout0_r !== 32'hB || dout0_valid_r !== 1'b1) begin
      errors++;
      $display("FAIL outreg_second: dout0=%h v=%b, want 0000000b/1", dout0_r, dout0_valid_r);
    end
    step();
    checks++;
    if (dout0_r !== 32'hB || dout0_valid_r !== 1'b0) begin
      errors++;
      $display("FAIL outreg_hold: dout0=%h v=%b, want 0000000b/0", dout0_r, dout0_valid_r);
    end
    checks++;
    if (dout1_r !== 32'h0 || dout1_valid_r !== 1'b0) begin
      errors++;
      $display("FAIL outreg_port1_idle: dout1=%h v=%b, want 0/0", dout1_r, dout1_valid_r);
    end
    idle();
  endtask

  task automatic test_reset_mid_clear();
    int n;
    bit saw_valid;
    rst_n = 1'b0;
    #1;
    checks++;
    if (dout0 !== 32'h0 || dout1 !== 32'h0 || dout0_r !== 32'h0 || init_busy !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: d0=%h d1=%h d0r=%h busy=%b, want 0/0/0/1",
               dout0, dout1, dout0_r, init_busy);
    end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) step();
    checks++;
    if (init_busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_at_100: init_busy=%b, want 1", init_busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (init_busy !== 1'b1 || dout0_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_clear: busy=%b v0=%b, want 1/0", init_busy, dout0_valid);
    end
    step();
    rst_n = 1'b1;
    n = 0;
    saw_valid = 1'b0;
    while (init_busy === 1'b1 && n < 400) begin
      if (n == 200) begin
        csb0 = 1'b0; web0 = 1'b0; addr0 = 8'h30; din0 = 32'h55; wmask0 = 4'hF;
        csb1 = 1'b0; addr1 = 8'h30;
      end
      step();
      n++;
      if (dout0_valid !== 1'b0 || dout1_valid !== 1'b0) saw_valid = 1'b1;
    end
    idle();
    checks++;
    if (n != 256) begin
      errors++;
      $display("FAIL restart_clear_length: got %0d cycles, want 256", n);
    end
    checks++;
    if (saw_valid !== 1'b0 || dout1 !== 32'h0) begin
      errors++;
      $display("FAIL busy_drop: saw_valid=%b dout1=%h, want 0/0", saw_valid, dout1);
    end
    csb1 = 1'b0; addr1 = 8'h30;
    csb0 = 1'b0; web0 = 1'b1; addr0 = 8'h10;
    step();
    idle();
    checks++;
    if (dout1 !== 32'h0 || dout1_valid !== 1'b1) begin
      errors++;
      $display("FAIL dropped_write: dout1=%h v=%b, want 0/1", dout1, dout1_valid);
    end
    checks++;
    if (dout0 !== 32'h0 || dout0_valid !== 1'b1) begin
      errors++;
      $display("FAIL recleared: dout0=%h v=%b, want 0/1", dout0, dout0_valid);
    end
  endtask

  initial begin
    test_reset();
    test_mask();
    test_write_first();
    test_back_to_back();
    test_reset_mid_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
